ps2_kbd_ctrl: RTL and testbench

//  Sequencer behind the PS/2 frame receiver: consumes raw 8-bit scan codes, strips E0/F0 prefixes,

---
 rtl/ps2_kbd_ctrl_pkg.sv | 27 ++
 rtl/ps2_kbd_ctrl_evt_fifo.sv | 45 ++++
 rtl/ps2_kbd_ctrl.sv | 128 ++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared constants and types for the PS/2 keyboard event sequencer.
// Event word layout: {brk, ext, code[7:0]}.
package ps2_kbd_ctrl_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int         EVT_BRK = 9;
  localparam int         EVT_EXT = 8;
  localparam int         EVT_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  function automatic logic [EVT_W-1:0] pack_evt(input logic brk, input logic ext,
                                                input logic [7:0] c);
    logic [EVT_W-1:0] e;
    e          = {2'b00, c};
    e[EVT_BRK] = brk;
    e[EVT_EXT] = ext;
    return e;
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_evt_fifo.sv
// Synchronous event FIFO with extra-MSB pointers; the parent decides drops.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module ps2_evt_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: strips E0/F0 prefixes, filters typematic repeats,
// and queues {brk, ext, code} events for a ready/valid consumer.
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [9:0] evt_data,
  output logic [7:0] press_cnt,
  output logic       overflow,
  input  logic       ovf_clr
);
  import ps2_kbd_ctrl_pkg::*;

  ps2_state_t state;
  ps2_state_t next_state;
  logic       emit;
  logic       emit_brk;
  logic       emit_ext;

  logic       lm_valid;
  logic       lm_ext;
  logic [7:0] lm_code;
  logic       lm_hit;
  logic       is_rep;
  logic       want_push;
  logic       pop;
  logic       push_ok;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_brk   = 1'b0;
    emit_ext   = 1'b0;
    if (code_valid) begin
      case (state)
        ST_IDLE: begin
          if (code == PS2_EXT)      next_state = ST_EXT;
          else if (code == PS2_BRK) next_state = ST_BRK;
          else                      emit = 1'b1;
        end
        ST_EXT: begin
          if (code == PS2_BRK)      next_state = ST_EXT_BRK;
          else if (code == PS2_EXT) next_state = ST_EXT;
          else begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_BRK: begin
          next_state = ST_IDLE;
          if (code != PS2_EXT && code != PS2_BRK) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          next_state = ST_IDLE;
          if (code != PS2_EXT && code != PS2_BRK) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = 1'b1;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // A repeat is a make identical to the currently held key; breaks are never filtered.
  assign lm_hit    = lm_valid && (lm_ext == emit_ext) && (lm_code == code);
  assign is_rep    = emit && !emit_brk && (REPEAT_EN == 1'b0) && lm_hit;
  assign want_push = emit && !is_rep;
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = want_push && (!fifo_full || pop);
  assign drop      = want_push && fifo_full && !pop;
  assign evt_valid = !fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lm_valid  <= 1'b0;
      lm_ext    <= 1'b0;
      lm_code   <= '0;
      press_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (emit && !emit_brk) begin
        lm_valid <= 1'b1;
        lm_ext   <= emit_ext;
        lm_code  <= code;
      end else if (emit && emit_brk && lm_hit) begin
        lm_valid <= 1'b0;
      end
      if (push_ok && !emit_brk) press_cnt <= press_cnt + 8'd1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push_ok),
    .wdata (pack_evt(emit_brk, emit_ext, code)),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (evt_data)
  );

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed spec scenarios plus random traffic,
// checked against a queue-based event model.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [9:0] evt_data;
  logic [7:0] press_cnt;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  logic       r_code_valid = 1'b0;
  logic [7:0] r_code = 8'h00;
  logic       r_evt_valid;
  logic       r_evt_ready = 1'b1;
  logic [9:0] r_evt_data;
  logic [7:0] r_press_cnt;
  logic       r_overflow;
  logic       r_ovf_clr = 1'b0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .REPEAT_EN(1'b0)) dut (
    .clk(clk), .resetn(resetn), .code_valid(code_valid), .code(code),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .press_cnt(press_cnt), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .REPEAT_EN(1'b1)) dut_r (
    .clk(clk), .resetn(resetn), .code_valid(r_code_valid), .code(r_code),
    .evt_valid(r_evt_valid), .evt_ready(r_evt_ready), .evt_data(r_evt_data),
    .press_cnt(r_press_cnt), .overflow(r_overflow), .ovf_clr(r_ovf_clr)
  );

  int tests = 0;
  int fails = 0;

  // Model: pending prefix flags, the held key, and the FIFO contents as a queue.
  logic [9:0] q[$];
  logic [9:0] dut_log[$];
  bit         m_ext, m_brk;
  bit         m_held_v;
  logic [8:0] m_held;
  logic [7:0] m_press;
  bit         m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ext = 0; m_brk = 0; m_held_v = 0; m_held = '0; m_press = '0; m_ovf = 0;
  endtask

  task automatic model_byte(input logic [7:0] c, output bit set_ovf);
    logic [9:0] e;
    bit         mk, keep;
    set_ovf = 0;
    if (c == 8'hE0 || c == 8'hF0) begin
      if (m_brk) begin
        m_ext = 0; m_brk = 0;
      end else if (c == 8'hE0) m_ext = 1;
      else m_brk = 1;
    end else begin
      e = {m_brk, m_ext, c};
      mk = !m_brk;
      keep = 1;
      if (mk) begin
        if (m_held_v && m_held == {m_ext, c}) keep = 0;
        m_held_v = 1; m_held = {m_ext, c};
      end else if (m_held_v && m_held == {m_ext, c}) begin
        m_held_v = 0;
      end
      m_ext = 0; m_brk = 0;
      if (keep) begin
        if (q.size() < DEPTH) begin
          q.push_back(e);
          if (mk) m_press = m_press + 8'd1;
        end else set_ovf = 1;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] c, input bit rdy, input bit clr = 1'b0);
    bit set_ovf;
    @(negedge clk);
    check("evt_valid", {31'd0, evt_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) check("evt_data", {22'd0, evt_data}, {22'd0, q[0]});
    check("press_cnt", {24'd0, press_cnt}, {24'd0, m_press});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    code_valid = v; code = c; evt_ready = rdy; ovf_clr = clr;
    if (rdy && q.size() != 0) begin
      dut_log.push_back(evt_data);
      void'(q.pop_front());
    end
    set_ovf = 0;
    if (v) model_byte(c, set_ovf);
    if (set_ovf) m_ovf = 1;
    else if (clr) m_ovf = 0;
    @(posedge clk);
    #1;
    code_valid = 0; evt_ready = 0; ovf_clr = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 1);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    resetn = 0; code_valid = 0; evt_ready = 0; ovf_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
    dut_log.delete();
  endtask

  task automatic r_send(input logic [7:0] c);
    @(negedge clk);
    r_code_valid = 1; r_code = c;
    @(posedge clk);
    #1 r_code_valid = 0;
  endtask

  logic [7:0] pool [7];

  initial begin
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C; pool[3] = 8'h32;
    pool[4] = 8'h75; pool[5] = 8'h2A; pool[6] = 8'hE1;

    // Reset state
    hard_reset();
    #1;
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_press_cnt", {24'd0, press_cnt}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // Make then break
    cycle(1, 8'h1C, 1); cycle(1, 8'hF0, 1); cycle(1, 8'h1C, 1); drain(3);
    check("mkbrk_count", dut_log.size(), 32'd2);
    check("mkbrk_ev0", {22'd0, dut_log[0]}, 32'h01C);
    check("mkbrk_ev1", {22'd0, dut_log[1]}, 32'h21C);
    check("mkbrk_press", {24'd0, press_cnt}, 32'd1);

    // Extended make/break
    hard_reset();
    cycle(1, 8'hE0, 1); cycle(1, 8'h75, 1);
    cycle(1, 8'hE0, 1); cycle(1, 8'hF0, 1); cycle(1, 8'h75, 1); drain(3);
    check("ext_count", dut_log.size(), 32'd2);
    check("ext_ev0", {22'd0, dut_log[0]}, 32'h175);
    check("ext_ev1", {22'd0, dut_log[1]}, 32'h375);

    // Typematic filter, both settings
    hard_reset();
    cycle(1, 8'h1C, 1); cycle(1, 8'h1C, 1); cycle(1, 8'h1C, 1);
    cycle(1, 8'hF0, 1); cycle(1, 8'h1C, 1); cycle(1, 8'h1C, 1); drain(3);
    check("rep_count", dut_log.size(), 32'd3);
    check("rep_ev0", {22'd0, dut_log[0]}, 32'h01C);
    check("rep_ev1", {22'd0, dut_log[1]}, 32'h21C);
    check("rep_ev2", {22'd0, dut_log[2]}, 32'h01C);
    check("rep_press", {24'd0, press_cnt}, 32'd2);
    r_send(8'h1C); r_send(8'h1C); r_send(8'h1C);
    r_send(8'hF0); r_send(8'h1C); r_send(8'h1C);
    repeat (2) @(negedge clk);
    check("rep_en_press", {24'd0, r_press_cnt}, 32'd4);

    // Overflow, push+pop while full, ovf_clr
    hard_reset();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, 8'h10 + 8'(i), 0);
    cycle(0, 8'h00, 0);
    check("full_ovf", {31'd0, overflow}, 32'd1);
    check("full_press", {24'd0, press_cnt}, DEPTH);
    cycle(1, 8'h40, 1);
    cycle(0, 8'h00, 0, 1'b1);
    cycle(0, 8'h00, 0);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    check("fullpop_press", {24'd0, press_cnt}, DEPTH + 1);
    drain(DEPTH + 2);
    check("fullpop_count", dut_log.size(), DEPTH + 1);
    check("fullpop_first", {22'd0, dut_log[0]}, 32'h010);
    check("fullpop_last", {22'd0, dut_log[DEPTH]}, 32'h040);

    // Async reset mid-prefix with events queued
    hard_reset();
    cycle(1, 8'h21, 0); cycle(1, 8'h22, 0); cycle(1, 8'h23, 0);
    cycle(1, 8'hE0, 0); cycle(1, 8'hF0, 0);
    @(negedge clk);
    check("pre_rst_press", {24'd0, press_cnt}, 32'd3);
    #2 resetn = 0;
    #1;
    check("async_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("async_press", {24'd0, press_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1;
    dut_log.delete();
    cycle(1, 8'h1C, 1); drain(2);
    check("post_rst_ev", {22'd0, dut_log[0]}, 32'h01C);

    // Malformed double break prefix
    hard_reset();
    cycle(1, 8'hF0, 1); cycle(1, 8'hF0, 1); cycle(1, 8'h2A, 1); drain(2);
    check("malf_count", dut_log.size(), 32'd1);
    check("malf_ev", {22'd0, dut_log[0]}, 32'h02A);

    // press_cnt wrap
    hard_reset();
    for (int i = 0; i < 256; i++) cycle(1, (i % 2) ? 8'h32 : 8'h1C, 1);
    drain(2);
    check("wrap_press", {24'd0, press_cnt}, 32'd0);

    // Random traffic against the model
    hard_reset();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, pool[$urandom_range(0, 6)],
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    drain(DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
